regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, number of buffered multi-cycle results (2..8).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive cycles a queued result may wait before the pipeline is stalled.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports wb_valid in 1, wb_register in 5, wb_data in 32: pipeline writeback request.
REQ-006 SHALL have port wb_stall  out  1  pipeline must hold its writeback request this cycle.
REQ-007 SHALL have ports md_valid in 1, md_register in 5, md_data in 32: multiply/divide result request; md_ready out 1 accept.
REQ-008 SHALL have ports md_issue in 1, md_issue_register in 5: multi-cycle op issued, destination becomes pending.
REQ-009 SHALL have ports pending_query_1 in 5, pending_query_2 in 5, pending_hit_1 out 1, pending_hit_2 out 1: scoreboard lookup for decode stall.
REQ-010 SHALL have ports register_write out 1, write_register out 5, write_data out 32: register-file write port.
REQ-011 SHALL have ports fifo_count out 4 (occupancy) and protocol_error out 1 (sticky).

Function
REQ-012 wb accepted when wb_valid && !wb_stall; md accepted when md_valid && md_ready; accepted md results enqueue in FIFO order.
REQ-013 md_ready = (fifo_count < FIFO_DEPTH), from registered count; full FIFO SHALL deassert md_ready even if a dequeue occurs that cycle.
REQ-014 Grant per cycle: accepted wb wins; else FIFO head dequeued if non-empty; else no grant.
REQ-015 Write outputs registered: grant in cycle N -> register_write/write_register/write_data valid in cycle N+1 for exactly one cycle.
REQ-016 Grant whose destination is 0 SHALL consume the request (dequeue if FIFO) but keep register_write low.
REQ-017 Starve counter increments each cycle FIFO is non-empty and head not dequeued; clears on dequeue or empty.
REQ-018 wb_stall registered: high in cycle after counter reaches STARVE_LIMIT with FIFO non-empty; while high, head SHALL be granted and counter cleared; wb_stall low the following cycle unless re-reached.
REQ-019 Pending vector 32 bits: md_issue sets bit md_issue_register (bit 0 never set); FIFO-head grant clears bit of its register.
REQ-020 Same-cycle set and clear of same bit: set wins, no error.
REQ-021 pending_hit_x combinational = pending[pending_query_x]; query 0 returns 0.
REQ-022 protocol_error SHALL set and hold on: md_issue to an already-pending non-zero register (unless cleared same cycle), md_valid to a non-pending non-zero register, or wb_valid targeting a pending register.
REQ-023 Erroneous requests are still processed per REQ-012..REQ-019.

Reset
REQ-024 rst_n low SHALL immediately force register_write, write_register, write_data, wb_stall, fifo_count, protocol_error, pending vector and starve counter to 0; md_ready=1 after release.
REQ-025 Reset mid-operation SHALL discard FIFO contents and any registered grant; no write issued for them.

Structure
REQ-026 Package regfile_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, NUM_REGS=32 and the {register, data} write-request record type.
REQ-027 FIFO SHALL be a sub-module regfile_wr_fifo (push/pop/count, depth parameter); arbitration, starve logic and scoreboard stay in the top.

Verification
REQ-028 md_issue r5; md result r5=0x1234 with idle wb -> register_write r5=0x1234 two cycles after md_valid, pending_hit on r5 drops same cycle as write.
REQ-029 wb r3=0xAAAA and md r7=0xBBBB same cycle -> r3 written cycle N+1, r7 cycle N+2, write order preserved.
REQ-030 Continuous wb_valid with one queued md result, STARVE_LIMIT=4 -> wb_stall high one cycle, md write emitted, wb resumes, no wb request lost.
REQ-031 Fill FIFO_DEPTH=2 while wb busy -> md_ready low, fifo_count=2, third md held; released after a dequeue.
REQ-032 md_issue r9 twice without completion -> protocol_error=1 and stays 1 until rst_n; wb to r0 -> no register_write.
REQ-033 Assert rst_n low with 2 queued entries -> outputs zero immediately, fifo_count=0, no subsequent write.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and the write-request record used by the register-file
// write arbiter and its result FIFO.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] register;
        logic [DATA_W-1:0]     data;
    } wr_req_t;

endpackage

// File: rtl/regfile_wr_fifo.sv
// Small circular FIFO holding multiply/divide results that are waiting for
// the register-file write port. Occupancy is registered.
module regfile_wr_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  wr_req_t    push_data,
    input  logic       pop,
    output wr_req_t    head,
    output logic [3:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [3:0]    DEPTH_C  = 4'(DEPTH);

    wr_req_t       mem_q [DEPTH];
    wr_req_t       mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // Overflowing pushes and underflowing pops are dropped, never wrapped.
    always_comb begin
        do_push  = push && (count_q < DEPTH_C);
        do_pop   = pop && (count_q != 4'd0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + 4'(do_push) - 4'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single register-file write port shared by the pipeline writeback and queued
// multiply/divide results, with anti-starvation stall and pending scoreboard.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_register,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  wb_stall,
    input  logic                  md_valid,
    input  logic [REG_ADDR_W-1:0] md_register,
    input  logic [DATA_W-1:0]     md_data,
    output logic                  md_ready,
    input  logic                  md_issue,
    input  logic [REG_ADDR_W-1:0] md_issue_register,
    input  logic [REG_ADDR_W-1:0] pending_query_1,
    input  logic [REG_ADDR_W-1:0] pending_query_2,
    output logic                  pending_hit_1,
    output logic                  pending_hit_2,
    output logic                  register_write,
    output logic [REG_ADDR_W-1:0] write_register,
    output logic [DATA_W-1:0]     write_data,
    output logic [3:0]            fifo_count,
    output logic                  protocol_error
);

    localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);
    localparam logic [3:0]    DEPTH_C = 4'(FIFO_DEPTH);

    // Handshakes: wb transfers when wb_valid && !wb_stall, md transfers when
    // md_valid && md_ready; a requester holds its payload until it transfers.
    logic                  wb_accept;
    logic                  md_accept;
    logic                  fifo_pop;
    logic                  fifo_nonempty;
    wr_req_t               fifo_head;
    wr_req_t               md_req;
    wr_req_t               grant;
    logic                  grant_valid;

    logic [SW-1:0]         starve_q, starve_d;
    logic                  wb_stall_q, wb_stall_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic                  error_q, error_d;
    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] write_register_q, write_register_d;
    logic [DATA_W-1:0]     write_data_q, write_data_d;
    logic                  issue_err, md_err, wb_err;

    assign md_ready      = (fifo_count < DEPTH_C);
    assign fifo_nonempty = (fifo_count != 4'd0);
    assign wb_accept     = wb_valid && !wb_stall_q;
    assign md_accept     = md_valid && md_ready;
    assign fifo_pop      = !wb_accept && fifo_nonempty;
    assign md_req        = '{register: md_register, data: md_data};

    regfile_wr_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (md_accept),
        .push_data(md_req),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    always_comb begin
        grant_valid = wb_accept || fifo_pop;
        grant       = wb_accept ? '{register: wb_register, data: wb_data} : fifo_head;

        // Register 0 grants are consumed but never reach the register file.
        reg_write_d      = grant_valid && (grant.register != '0);
        write_register_d = reg_write_d ? grant.register : '0;
        write_data_d     = reg_write_d ? grant.data : '0;

        if (!fifo_nonempty || fifo_pop) begin
            starve_d = '0;
        end else if (starve_q != LIMIT_C) begin
            starve_d = starve_q + 1'b1;
        end else begin
            starve_d = starve_q;
        end
        wb_stall_d = (starve_d >= LIMIT_C);

        // A same-cycle issue overrides the clear from the head grant.
        pending_d = pending_q;
        if (fifo_pop) begin
            pending_d[fifo_head.register] = 1'b0;
        end
        if (md_issue && (md_issue_register != '0)) begin
            pending_d[md_issue_register] = 1'b1;
        end

        issue_err = md_issue && (md_issue_register != '0) && pending_q[md_issue_register]
                    && !(fifo_pop && (fifo_head.register == md_issue_register));
        md_err    = md_valid && (md_register != '0) && !pending_q[md_register];
        wb_err    = wb_valid && (wb_register != '0) && pending_q[wb_register];
        error_d   = error_q || issue_err || md_err || wb_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q         <= '0;
            wb_stall_q       <= 1'b0;
            pending_q        <= '0;
            error_q          <= 1'b0;
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
        end else begin
            starve_q         <= starve_d;
            wb_stall_q       <= wb_stall_d;
            pending_q        <= pending_d;
            error_q          <= error_d;
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
        end
    end

    assign pending_hit_1  = (pending_query_1 != '0) && pending_q[pending_query_1];
    assign pending_hit_2  = (pending_query_2 != '0) && pending_q[pending_query_2];
    assign wb_stall       = wb_stall_q;
    assign register_write = reg_write_q;
    assign write_register = write_register_q;
    assign write_data     = write_data_q;
    assign protocol_error = error_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_regfile_write_arbiter;

    localparam int DEPTH  = 2;
    localparam int STARVE = 4;
    localparam int W      = 37;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_register = '0;
    logic [31:0] wb_data = '0;
    logic        wb_stall;
    logic        md_valid = 1'b0;
    logic [4:0]  md_register = '0;
    logic [31:0] md_data = '0;
    logic        md_ready;
    logic        md_issue = 1'b0;
    logic [4:0]  md_issue_register = '0;
    logic [4:0]  pending_query_1 = '0;
    logic [4:0]  pending_query_2 = '0;
    logic        pending_hit_1;
    logic        pending_hit_2;
    logic        register_write;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic [3:0]  fifo_count;
    logic        protocol_error;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    regfile_write_arbiter #(
        .FIFO_DEPTH  (DEPTH),
        .STARVE_LIMIT(STARVE)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wb_valid         (wb_valid),
        .wb_register      (wb_register),
        .wb_data          (wb_data),
        .wb_stall         (wb_stall),
        .md_valid         (md_valid),
        .md_register      (md_register),
        .md_data          (md_data),
        .md_ready         (md_ready),
        .md_issue         (md_issue),
        .md_issue_register(md_issue_register),
        .pending_query_1  (pending_query_1),
        .pending_query_2  (pending_query_2),
        .pending_hit_1    (pending_hit_1),
        .pending_hit_2    (pending_hit_2),
        .register_write   (register_write),
        .write_register   (write_register),
        .write_data       (write_data),
        .fifo_count       (fifo_count),
        .protocol_error   (protocol_error)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        wb_valid = 1'b0; wb_register = '0; wb_data = '0;
        md_valid = 1'b0; md_register = '0; md_data = '0;
        md_issue = 1'b0; md_issue_register = '0;
    endtask

    task automatic issue(input logic [4:0] r);
        md_issue = 1'b1; md_issue_register = r;
        cycle();
        md_issue = 1'b0; md_issue_register = '0;
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] mq[$];
    logic [31:0]  m_pend  = '0;
    int           m_wait  = 0;
    bit           m_stall = 1'b0;
    bit           m_wr    = 1'b0;
    logic [4:0]   m_wreg  = '0;
    logic [31:0]  m_wdata = '0;
    bit           m_err   = 1'b0;

    initial begin
        int           sz;
        bit           wb_acc, md_acc, popped, gv;
        logic [W-1:0] g;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_pend = '0; m_wait = 0; m_stall = 1'b0;
                m_wr = 1'b0; m_wreg = '0; m_wdata = '0; m_err = 1'b0;
            end else begin
                sz     = mq.size();
                wb_acc = wb_valid && !m_stall;
                md_acc = md_valid && (sz < DEPTH);
                popped = 1'b0; gv = 1'b0; g = '0;
                if (wb_acc) begin
                    gv = 1'b1; g = {wb_register, wb_data};
                end else if (sz > 0) begin
                    gv = 1'b1; g = mq.pop_front(); popped = 1'b1;
                end
                if (md_issue && md_issue_register != 0 && m_pend[md_issue_register]
                    && !(popped && g[36:32] == md_issue_register)) m_err = 1'b1;
                if (md_valid && md_register != 0 && !m_pend[md_register]) m_err = 1'b1;
                if (wb_valid && wb_register != 0 && m_pend[wb_register]) m_err = 1'b1;
                if (popped) m_pend[g[36:32]] = 1'b0;
                if (md_issue && md_issue_register != 0) m_pend[md_issue_register] = 1'b1;
                m_wait  = (sz > 0 && !popped) ? m_wait + 1 : 0;
                m_stall = (m_wait >= STARVE);
                if (md_acc) mq.push_back({md_register, md_data});
                m_wr    = gv && (g[36:32] != 0);
                m_wreg  = m_wr ? g[36:32] : 5'd0;
                m_wdata = m_wr ? g[31:0] : 32'd0;
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && chk_on) begin
                check("m_register_write", 32'(register_write), 32'(m_wr));
                check("m_write_register", 32'(write_register), 32'(m_wreg));
                check("m_write_data", write_data, m_wdata);
                check("m_wb_stall", 32'(wb_stall), 32'(m_stall));
                check("m_md_ready", 32'(md_ready), 32'(mq.size() < DEPTH));
                check("m_fifo_count", 32'(fifo_count), 32'(mq.size()));
                check("m_protocol_error", 32'(protocol_error), 32'(m_err));
                check("m_pending_hit_1", 32'(pending_hit_1),
                      32'(pending_query_1 != 0 && m_pend[pending_query_1]));
                check("m_pending_hit_2", 32'(pending_hit_2),
                      32'(pending_query_2 != 0 && m_pend[pending_query_2]));
            end
        end
    end

    // ---------------- directed scenarios ----------------
    logic [W-1:0] exp_q[$];

    initial begin
        int k;
        int stall_cnt;
        logic [W-1:0] e;
        bit acc;

        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_register_write", 32'(register_write), 32'd0);
        check("rst_wb_stall", 32'(wb_stall), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_protocol_error", 32'(protocol_error), 32'd0);
        rst_n = 1'b1;
        chk_on = 1'b1;
        cycle();
        check("rst_md_ready", 32'(md_ready), 32'd1);

        // md result r5 with idle writeback
        pending_query_1 = 5'd5; pending_query_2 = 5'd0;
        issue(5'd5);
        check("s1_hit_r5", 32'(pending_hit_1), 32'd1);
        check("s1_hit_q0", 32'(pending_hit_2), 32'd0);
        md_valid = 1'b1; md_register = 5'd5; md_data = 32'h1234;
        cycle();
        drive_idle();
        check("s1_no_write_yet", 32'(register_write), 32'd0);
        check("s1_count1", 32'(fifo_count), 32'd1);
        cycle();
        check("s1_write", 32'(register_write), 32'd1);
        check("s1_reg", 32'(write_register), 32'd5);
        check("s1_data", write_data, 32'h1234);
        check("s1_hit_dropped", 32'(pending_hit_1), 32'd0);
        cycle();
        check("s1_one_cycle", 32'(register_write), 32'd0);

        // simultaneous wb r3 and md r7: order preserved
        issue(5'd7);
        wb_valid = 1'b1; wb_register = 5'd3; wb_data = 32'hAAAA;
        md_valid = 1'b1; md_register = 5'd7; md_data = 32'hBBBB;
        cycle();
        drive_idle();
        check("s2_first_reg", 32'(write_register), 32'd3);
        check("s2_first_data", write_data, 32'hAAAA);
        cycle();
        check("s2_second_reg", 32'(write_register), 32'd7);
        check("s2_second_data", write_data, 32'hBBBB);
        cycle();
        check("s2_done", 32'(register_write), 32'd0);

        // continuous writeback starving one queued md result
        issue(5'd10);
        exp_q.delete();
        exp_q.push_back({5'd2, 32'h101}); exp_q.push_back({5'd2, 32'h102});
        exp_q.push_back({5'd2, 32'h103}); exp_q.push_back({5'd2, 32'h104});
        exp_q.push_back({5'd2, 32'h105}); exp_q.push_back({5'd10, 32'hCAFE});
        exp_q.push_back({5'd2, 32'h106}); exp_q.push_back({5'd2, 32'h107});
        k = 1; stall_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            wb_valid = 1'b1; wb_register = 5'd2; wb_data = 32'h100 + 32'(k);
            md_valid = (i == 0); md_register = 5'd10; md_data = 32'hCAFE;
            acc = !wb_stall;
            cycle();
            if (acc) k++;
            if (wb_stall) stall_cnt++;
            if (register_write) begin
                if (exp_q.size() == 0) begin
                    check("s3_extra_write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("s3_write_reg", 32'(write_register), 32'(e[36:32]));
                    check("s3_write_data", write_data, e[31:0]);
                end
            end
        end
        drive_idle();
        check("s3_stall_cycles", 32'(stall_cnt), 32'd1);
        check("s3_all_writes_seen", 32'(exp_q.size()), 32'd0);
        cycle();
        check("s3_quiet", 32'(register_write), 32'd0);

        // fill the FIFO while writeback is busy
        issue(5'd11); issue(5'd12); issue(5'd13);
        wb_valid = 1'b1; wb_register = 5'd2; wb_data = 32'h200;
        md_valid = 1'b1; md_register = 5'd11; md_data = 32'h11;
        cycle();
        md_register = 5'd12; md_data = 32'h12;
        cycle();
        check("s4_full_ready", 32'(md_ready), 32'd0);
        check("s4_full_count", 32'(fifo_count), 32'd2);
        md_register = 5'd13; md_data = 32'h13;
        cycle();
        check("s4_held_ready", 32'(md_ready), 32'd0);
        check("s4_held_count", 32'(fifo_count), 32'd2);
        wb_valid = 1'b0;
        cycle();
        check("s4_pop1_reg", 32'(write_register), 32'd11);
        check("s4_pop1_count", 32'(fifo_count), 32'd1);
        check("s4_pop1_ready", 32'(md_ready), 32'd1);
        cycle();
        md_valid = 1'b0;
        check("s4_pop2_reg", 32'(write_register), 32'd12);
        check("s4_pop2_count", 32'(fifo_count), 32'd1);
        cycle();
        check("s4_pop3_reg", 32'(write_register), 32'd13);
        check("s4_pop3_data", write_data, 32'h13);
        check("s4_empty", 32'(fifo_count), 32'd0);
        drive_idle();

        // double issue to r9, then writeback to r0
        check("s5_no_error_yet", 32'(protocol_error), 32'd0);
        issue(5'd9);
        issue(5'd9);
        check("s5_error_set", 32'(protocol_error), 32'd1);
        wb_valid = 1'b1; wb_register = 5'd0; wb_data = 32'hDEAD;
        cycle();
        drive_idle();
        check("s5_r0_no_write", 32'(register_write), 32'd0);
        repeat (3) cycle();
        check("s5_error_sticky", 32'(protocol_error), 32'd1);

        // reset with two queued entries
        issue(5'd14); issue(5'd15);
        pending_query_1 = 5'd14; pending_query_2 = 5'd15;
        wb_valid = 1'b1; wb_register = 5'd2; wb_data = 32'h300;
        md_valid = 1'b1; md_register = 5'd14; md_data = 32'h14;
        cycle();
        md_register = 5'd15; md_data = 32'h15;
        cycle();
        check("s6_count2", 32'(fifo_count), 32'd2);
        check("s6_writing", 32'(register_write), 32'd1);
        #2;
        rst_n = 1'b0;
        drive_idle();
        #1;
        check("s6_rst_write", 32'(register_write), 32'd0);
        check("s6_rst_reg", 32'(write_register), 32'd0);
        check("s6_rst_data", write_data, 32'd0);
        check("s6_rst_stall", 32'(wb_stall), 32'd0);
        check("s6_rst_count", 32'(fifo_count), 32'd0);
        check("s6_rst_error", 32'(protocol_error), 32'd0);
        check("s6_rst_hit1", 32'(pending_hit_1), 32'd0);
        check("s6_rst_hit2", 32'(pending_hit_2), 32'd0);
        repeat (2) cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("s6_no_write_after", 32'(register_write), 32'd0);
            check("s6_count_after", 32'(fifo_count), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
